multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multi-cycle MIPS control FSM; the initiator side of the ALU interface. It issues ALU control codes and operand selects, and consumes the ALU's zero flag.
- The ALU is registered: result and zero appear one cycle after control is applied. The FSM schedules around this latency.
- Also sequences instruction fetch, memory access (with a ready handshake), register write-back and PC update for R-type, lw, sw, beq and j.

Parameters:
- RESET_STATE, 4'd0 (FETCH): state entered on reset.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- opcode  in  6  instruction register [31:26], valid from DECODE onward
- funct  in  6  instruction register [5:0]
- zero  in  1  ALU zero flag (registered, one-cycle latency)
- mem_ready  in  1  memory access complete this cycle
- alu_control  out  4  add 0010, sub 0110, and 0000, or 0001, slt 0111
- alu_src_a  out  1  0 = PC, 1 = reg rs
- alu_src_b  out  2  00 = rt, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
- iord  out  1  memory address: 0 = PC, 1 = ALU output
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  load instruction register
- pc_write  out  1  load PC
- pc_source  out  2  00 = ALU output, 10 = jump target
- reg_write  out  1  register file write enable
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  0 = ALU output, 1 = memory data register
- illegal  out  1  sticky unsupported-instruction flag
- state_dbg  out  4  current state encoding

Behaviour:
- Moore outputs, decoded from the state register only, except ir_write (see FETCH).
- Defaults: all strobes 0, alu_control = 0010, selects 0.
- Reset (synchronous, any state, including mid-MEM) forces FETCH, clears illegal and the taken flag, and all strobes are 0 during the reset cycle.
- FETCH:
  - mem_read = 1, iord = 0; ALU add, src_a = 0, src_b = 01 (PC+4 computed every cycle).
  - Stay in FETCH while mem_ready = 0.
  - When mem_ready = 1: ir_write = 1 (combinational on mem_ready in FETCH only), then go to DECODE.
- DECODE:
  - pc_write = 1, pc_source = 00. The ALU output holds PC+4 from the last FETCH cycle.
  - Dispatch: 000000 -> EXEC; 100011 / 101011 -> ADDR; 000100 -> BRANCH; 000010 -> JUMP; other -> ERROR.
- EXEC:
  - src_a = 1, src_b = 00; alu_control from funct.
  - funct map: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - Unsupported funct -> ERROR (no write). Otherwise -> RWB.
- RWB: reg_write = 1, reg_dst = 1, mem_to_reg = 0 -> FETCH.
- ADDR: add, src_a = 1, src_b = 10 -> MEM.
- MEM:
  - iord = 1; the ALU inputs are held identical to ADDR so the address stays stable.
  - mem_read = 1 for lw, mem_write = 1 for sw; the request is held until mem_ready.
  - When mem_ready = 1: lw -> LWB, sw -> FETCH.
- LWB: reg_write = 1, reg_dst = 0, mem_to_reg = 1 -> FETCH.
- BRANCH: sub, src_a = 1, src_b = 00 -> BR_WAIT.
- BR_WAIT:
  - zero is now valid and is latched into the internal taken flag.
  - Drive add, src_a = 0, src_b = 11 (PC is already PC+4) -> BR_TAKE.
- BR_TAKE: pc_write = taken, pc_source = 00 -> FETCH.
- JUMP: pc_write = 1, pc_source = 10 -> FETCH.
- ERROR: illegal = 1, all strobes 0; stays until reset.
- Latency with zero-wait memory:
  - R-type 4 cycles, lw 5, sw 4, beq 5, j 3.
  - Each mem_ready = 0 cycle in FETCH or MEM adds one cycle.
- mem_ready outside FETCH/MEM is ignored. mem_read and mem_write are never asserted together.

Decomposition:
- Shared header/package: opcode constants, funct constants, ALU control codes, alu_src_b / pc_source encodings, state encodings.
- Sub-module alu_control_decode: combinational funct -> {alu_control, funct_valid}. Reused by EXEC.

Test Plan:
- add (opcode 0, funct 100000), mem_ready = 1 on first FETCH cycle -> states FETCH, DECODE, EXEC, RWB. alu_control = 0010 in EXEC; reg_write = 1 and reg_dst = 1 only in RWB; 4 cycles total.
- lw (100011) with mem_ready low 2 cycles in MEM -> mem_read = 1 and iord = 1 for 3 MEM cycles, alu_control/src_b constant (0010/10); LWB has mem_to_reg = 1; 7 cycles total.
- beq with zero = 1 in BR_WAIT -> pc_write = 1 in BR_TAKE. Repeat with zero = 0 -> pc_write = 0. Changing zero during BR_TAKE has no effect on the result.
- j (000010) -> pc_write = 1, pc_source = 10 in JUMP; back in FETCH on cycle 4.
- opcode 111111, then R-type with funct 000111 -> illegal = 1, state_dbg = ERROR, no reg_write/mem_write; held until reset.
- reset asserted in MEM during sw with mem_ready = 0 -> next cycle state = FETCH, mem_write = 0, illegal = 0.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: states, opcodes, funct codes, ALU codes, select values.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC    = 4'd2,
    S_RWB     = 4'd3,
    S_ADDR    = 4'd4,
    S_MEM     = 4'd5,
    S_LWB     = 4'd6,
    S_BRANCH  = 4'd7,
    S_BR_WAIT = 4'd8,
    S_BR_TAKE = 4'd9,
    S_JUMP    = 4'd10,
    S_ERROR   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU  = 2'b00;
  localparam logic [1:0] PCSRC_JUMP = 2'b10;

endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if - control outputs and status inputs between the FSM and the datapath.
interface multicycle_control_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic [3:0] alu_control;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       pc_write;
  logic [1:0] pc_source;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       illegal;
  logic [3:0] state_dbg;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output alu_control, alu_src_a, alu_src_b, iord, mem_read, mem_write,
           ir_write, pc_write, pc_source, reg_write, reg_dst, mem_to_reg,
           illegal, state_dbg
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  alu_control, alu_src_a, alu_src_b, iord, mem_read, mem_write,
           ir_write, pc_write, pc_source, reg_write, reg_dst, mem_to_reg,
           illegal, state_dbg
  );
endinterface

// File: rtl/multicycle_control_alu_control_decode.sv
// alu_control_decode - maps an R-type funct field to an ALU control code and a supported flag.
module alu_control_decode
  import multicycle_control_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [3:0] alu_control_o,
  output logic       funct_valid_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    funct_valid_o = 1'b1;
    case (funct_i)
      FN_ADD:  alu_control_o = ALU_ADD;
      FN_SUB:  alu_control_o = ALU_SUB;
      FN_AND:  alu_control_o = ALU_AND;
      FN_OR:   alu_control_o = ALU_OR;
      FN_SLT:  alu_control_o = ALU_SLT;
      default: funct_valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control - Moore control FSM for a multi-cycle MIPS datapath with a registered ALU.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic                  clk,
  input  logic                  reset,
  multicycle_control_if.master  bus
);

  state_e     state_q, state_d;
  logic       taken_q, taken_d;
  logic       illegal_q, illegal_d;
  logic [3:0] dec_alu;
  logic       dec_valid;

  alu_control_decode u_alu_dec (
    .funct_i       (bus.funct),
    .alu_control_o (dec_alu),
    .funct_valid_o (dec_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= state_e'(RESET_STATE);
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      taken_q   <= taken_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    taken_d         = taken_q;
    bus.alu_control = ALU_ADD;
    bus.alu_src_a   = 1'b0;
    bus.alu_src_b   = SRCB_RT;
    bus.iord        = 1'b0;
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.ir_write    = 1'b0;
    bus.pc_write    = 1'b0;
    bus.pc_source   = PCSRC_ALU;
    bus.reg_write   = 1'b0;
    bus.reg_dst     = 1'b0;
    bus.mem_to_reg  = 1'b0;

    // Outputs stay at defaults for the whole reset cycle, whatever state we are in.
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          bus.mem_read  = 1'b1;
          bus.alu_src_b = SRCB_FOUR;
          if (bus.mem_ready) begin
            bus.ir_write = 1'b1;
            state_d      = S_DECODE;
          end
        end
        S_DECODE: begin
          bus.pc_write = 1'b1;
          case (bus.opcode)
            OP_RTYPE:     state_d = S_EXEC;
            OP_LW, OP_SW: state_d = S_ADDR;
            OP_BEQ:       state_d = S_BRANCH;
            OP_J:         state_d = S_JUMP;
            default:      state_d = S_ERROR;
          endcase
        end
        S_EXEC: begin
          bus.alu_src_a   = 1'b1;
          bus.alu_control = dec_alu;
          state_d         = dec_valid ? S_RWB : S_ERROR;
        end
        S_RWB: begin
          bus.reg_write = 1'b1;
          bus.reg_dst   = 1'b1;
          state_d       = S_FETCH;
        end
        S_ADDR: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = SRCB_IMM;
          state_d       = S_MEM;
        end
        S_MEM: begin
          // ALU inputs mirror ADDR so the registered address cannot drift while stalled.
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = SRCB_IMM;
          bus.iord      = 1'b1;
          bus.mem_read  = (bus.opcode == OP_LW);
          bus.mem_write = (bus.opcode == OP_SW);
          if (bus.mem_ready) state_d = (bus.opcode == OP_LW) ? S_LWB : S_FETCH;
        end
        S_LWB: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = 1'b1;
          state_d        = S_FETCH;
        end
        S_BRANCH: begin
          bus.alu_control = ALU_SUB;
          bus.alu_src_a   = 1'b1;
          state_d         = S_BR_WAIT;
        end
        S_BR_WAIT: begin
          taken_d       = bus.zero;
          bus.alu_src_b = SRCB_IMM_SH;
          state_d       = S_BR_TAKE;
        end
        S_BR_TAKE: begin
          bus.pc_write = taken_q;
          state_d      = S_FETCH;
        end
        S_JUMP: begin
          bus.pc_write  = 1'b1;
          bus.pc_source = PCSRC_JUMP;
          state_d       = S_FETCH;
        end
        default: state_d = S_ERROR;
      endcase
    end

    illegal_d = illegal_q | (state_d == S_ERROR);
  end

  assign bus.state_dbg = state_q;
  assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control - scoreboard bench: per-cycle expected output vectors queued at drive time, compared when sampled.
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  logic clk = 1'b0;
  logic reset;
  multicycle_control_if bus ();

  multicycle_control #(.RESET_STATE(4'd0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic tk_m = 1'b0;
  logic [21:0] sb [$];

  function automatic logic [3:0] alu_of(input logic [5:0] fn);
    case (fn)
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b101010: return 4'b0111;
      default:   return 4'b0010;
    endcase
  endfunction

  // Expected output vector for one cycle, written from the control table of the design.
  function automatic logic [21:0] exp_of(input logic [3:0] st, input logic [5:0] op, fn,
                                         input logic mr, tk, rst);
    logic [3:0] alu = 4'b0010;
    logic sa = 0, io = 0, mrd = 0, mw = 0, irw = 0, pcw = 0, rw = 0, rd = 0, m2r = 0;
    logic [1:0] sbv = 2'b00, pcs = 2'b00;
    if (!rst) begin
      case (st)
        4'd0:  begin mrd = 1; sbv = 2'b01; irw = mr; end
        4'd1:  pcw = 1;
        4'd2:  begin sa = 1; alu = alu_of(fn); end
        4'd3:  begin rw = 1; rd = 1; end
        4'd4:  begin sa = 1; sbv = 2'b10; end
        4'd5:  begin sa = 1; sbv = 2'b10; io = 1;
                     mrd = (op == 6'b100011); mw = (op == 6'b101011); end
        4'd6:  begin rw = 1; m2r = 1; end
        4'd7:  begin sa = 1; alu = 4'b0110; end
        4'd8:  sbv = 2'b11;
        4'd9:  pcw = tk;
        4'd10: begin pcw = 1; pcs = 2'b10; end
        default: ;
      endcase
    end
    return {st, alu, sa, sbv, io, mrd, mw, irw, pcw, pcs, rw, rd, m2r, (st == 4'd11)};
  endfunction

  function automatic logic [21:0] obs();
    return {bus.state_dbg, bus.alu_control, bus.alu_src_a, bus.alu_src_b, bus.iord,
            bus.mem_read, bus.mem_write, bus.ir_write, bus.pc_write, bus.pc_source,
            bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.illegal};
  endfunction

  task automatic drive_cycle(input logic mr, z, rst, input logic [3:0] st);
    bus.mem_ready = mr;
    bus.zero      = z;
    reset         = rst;
    if (rst) tk_m = 1'b0;
    sb.push_back(exp_of(st, bus.opcode, bus.funct, mr, tk_m, rst));
    if (st == 4'd8 && !rst) tk_m = z;
  endtask

  task automatic test_reset();
    logic [21:0] e, g;
    logic       rs  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [3:0] sts [4] = '{4'd0, 4'd0, 4'd0, 4'd0};
    bus.opcode = 6'b000000; bus.funct = 6'b100000;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b0, 1'b0, rs[i], sts[i]);
      #1; e = sb.pop_front(); g = obs(); n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL reset[%0d] got=%h exp=%h", i, g, e); end
      @(negedge clk);
    end
  endtask

  task automatic test_rtype(input logic [5:0] fn, input string name);
    logic [21:0] e, g;
    logic [3:0] sts [4] = '{S_FETCH, S_DECODE, S_EXEC, S_RWB};
    logic       mrs [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    bus.opcode = 6'b000000; bus.funct = fn;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(mrs[i], 1'b0, 1'b0, sts[i]);
      #1; e = sb.pop_front(); g = obs(); n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL %s[%0d] got=%h exp=%h", name, i, g, e); end
      @(negedge clk);
    end
  endtask

  task automatic test_lw_stall();
    logic [21:0] e, g;
    logic [3:0] sts [8] = '{S_FETCH, S_DECODE, S_ADDR, S_MEM, S_MEM, S_MEM, S_LWB, S_FETCH};
    logic       mrs [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    bus.opcode = 6'b100011; bus.funct = 6'b000000;
    for (int i = 0; i < 8; i++) begin
      drive_cycle(mrs[i], 1'b0, 1'b0, sts[i]);
      #1; e = sb.pop_front(); g = obs(); n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL lw_stall[%0d] got=%h exp=%h", i, g, e); end
      @(negedge clk);
    end
  endtask

  task automatic test_sw();
    logic [21:0] e, g;
    logic [3:0] sts [5] = '{S_FETCH, S_DECODE, S_ADDR, S_MEM, S_FETCH};
    logic       mrs [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    bus.opcode = 6'b101011; bus.funct = 6'b000000;
    for (int i = 0; i < 5; i++) begin
      drive_cycle(mrs[i], 1'b0, 1'b0, sts[i]);
      #1; e = sb.pop_front(); g = obs(); n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL sw[%0d] got=%h exp=%h", i, g, e); end
      @(negedge clk);
    end
  endtask

  task automatic test_beq(input logic zw, input string name);
    logic [21:0] e, g;
    logic [3:0] sts [6] = '{S_FETCH, S_DECODE, S_BRANCH, S_BR_WAIT, S_BR_TAKE, S_FETCH};
    logic       zs  [6];
    // zero carries the opposite value outside BR_WAIT, so only the BR_WAIT sample may matter.
    for (int i = 0; i < 6; i++) zs[i] = (i == 3) ? zw : ~zw;
    bus.opcode = 6'b000100; bus.funct = 6'b000000;
    for (int i = 0; i < 6; i++) begin
      drive_cycle(i == 0, zs[i], 1'b0, sts[i]);
      #1; e = sb.pop_front(); g = obs(); n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL %s[%0d] got=%h exp=%h", name, i, g, e); end
      @(negedge clk);
    end
  endtask

  task automatic test_jump();
    logic [21:0] e, g;
    logic [3:0] sts [4] = '{S_FETCH, S_DECODE, S_JUMP, S_FETCH};
    bus.opcode = 6'b000010; bus.funct = 6'b000000;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(i == 0, 1'b0, 1'b0, sts[i]);
      #1; e = sb.pop_front(); g = obs(); n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL jump[%0d] got=%h exp=%h", i, g, e); end
      @(negedge clk);
    end
  endtask

  task automatic test_illegal(input logic [5:0] op, fn, input logic [3:0] third, input string name);
    logic [21:0] e, g;
    logic [3:0] sts [8] = '{S_FETCH, S_DECODE, third, S_ERROR, S_ERROR, S_ERROR, S_ERROR, S_FETCH};
    logic       mrs [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       rs  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    bus.opcode = op; bus.funct = fn;
    for (int i = 0; i < 8; i++) begin
      drive_cycle(mrs[i], 1'b1, rs[i], sts[i]);
      #1; e = sb.pop_front(); g = obs(); n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL %s[%0d] got=%h exp=%h", name, i, g, e); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_mem();
    logic [21:0] e, g;
    logic [3:0] sts [7] = '{S_FETCH, S_DECODE, S_ADDR, S_MEM, S_MEM, S_FETCH, S_FETCH};
    logic       mrs [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       rs  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    bus.opcode = 6'b101011; bus.funct = 6'b000000;
    for (int i = 0; i < 7; i++) begin
      drive_cycle(mrs[i], 1'b0, rs[i], sts[i]);
      #1; e = sb.pop_front(); g = obs(); n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL reset_mid_mem[%0d] got=%h exp=%h", i, g, e); end
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.opcode = 6'b000000; bus.funct = 6'b000000;
    bus.zero = 1'b0; bus.mem_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_rtype(6'b100000, "rtype_add");
    test_rtype(6'b100010, "b2b_sub");
    test_rtype(6'b100100, "b2b_and");
    test_rtype(6'b100101, "b2b_or");
    test_rtype(6'b101010, "b2b_slt");
    test_lw_stall();
    test_sw();
    test_beq(1'b1, "beq_taken");
    test_beq(1'b0, "beq_not_taken");
    test_jump();
    test_illegal(6'b111111, 6'b000000, S_ERROR, "bad_opcode");
    test_illegal(6'b000000, 6'b000111, S_EXEC, "bad_funct");
    test_reset_mid_mem();
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
